// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared state type and default sizes for the SRAM port arbiter
package sram_ctrl_pkg;

    localparam int DEF_NUM_WMASKS = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEPTH          = 1 << DEF_ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with one-hot grants
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // 0: requester a has priority on a tie, 1: requester b
    logic r_ptr;

    // grant the lone requester, or the pointed-to one on a tie
    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            o_gnt[0] = i_req[0] && (!i_req[1] || !r_ptr);
            o_gnt[1] = i_req[1] && (!i_req[0] ||  r_ptr);
        end
    end

    // after any accept, priority moves to the requester that was not served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (o_gnt[0]) begin
            r_ptr <= 1'b1;
        end else if (o_gnt[1]) begin
            r_ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - clears a single-port SRAM, then shares port 0 between two requesters
module sram_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int NUM_WMASKS = DEF_NUM_WMASKS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  init_done,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [NUM_WMASKS-1:0] a_wmask,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [NUM_WMASKS-1:0] b_wmask,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  r_init_done;
    logic                  r_a_rsp_valid;
    logic                  r_b_rsp_valid;
    logic                  w_arb_en;
    logic [1:0]            w_gnt;

    // a clear request wins over both requesters in the cycle it is seen
    assign w_arb_en = (r_state == RUN) && !clear_req;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_arb_en),
        .i_req ({b_valid, a_valid}),
        .o_gnt (w_gnt)
    );

    assign a_ready     = w_gnt[0];
    assign b_ready     = w_gnt[1];
    assign init_done   = r_init_done;
    assign a_rsp_valid = r_a_rsp_valid;
    assign b_rsp_valid = r_b_rsp_valid;
    assign a_rsp_rdata = r_a_rsp_valid ? sram_dout0 : '0;
    assign b_rsp_rdata = r_b_rsp_valid ? sram_dout0 : '0;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next state and macro port drive; port is idle and zeroed while reset is held
    always_comb begin
        w_next_state = r_state;
        sram_csb0    = 1'b1;
        sram_web0    = 1'b1;
        sram_wmask0  = '0;
        sram_addr0   = '0;
        sram_din0    = '0;
        case (r_state)
            CLEAR: begin
                if (r_clr_addr == LAST_ADDR) begin
                    w_next_state = RUN;
                end
                if (rst_n) begin
                    sram_csb0   = 1'b0;
                    sram_web0   = 1'b0;
                    sram_wmask0 = '1;
                    sram_addr0  = r_clr_addr;
                end
            end
            RUN: begin
                if (clear_req) begin
                    w_next_state = CLEAR;
                end else if (w_gnt[0]) begin
                    sram_csb0   = 1'b0;
                    sram_web0   = ~a_we;
                    sram_wmask0 = a_wmask;
                    sram_addr0  = a_addr;
                    sram_din0   = a_wdata;
                end else if (w_gnt[1]) begin
                    sram_csb0   = 1'b0;
                    sram_web0   = ~b_we;
                    sram_wmask0 = b_wmask;
                    sram_addr0  = b_addr;
                    sram_din0   = b_wdata;
                end
            end
        endcase
    end

    // sweep counter, done flag and one-cycle read response strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_addr    <= '0;
            r_init_done   <= 1'b0;
            r_a_rsp_valid <= 1'b0;
            r_b_rsp_valid <= 1'b0;
        end else begin
            r_clr_addr    <= (r_state == CLEAR) ? r_clr_addr + 1'b1 : '0;
            r_init_done   <= (w_next_state == RUN);
            r_a_rsp_valid <= w_gnt[0] && !a_we;
            r_b_rsp_valid <= w_gnt[1] && !b_we;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
    import sram_ctrl_pkg::*;

    localparam int NW = 4;
    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_req;
    logic          init_done;
    logic          a_valid, a_ready, a_we, a_rsp_valid;
    logic [NW-1:0] a_wmask;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rsp_rdata;
    logic          b_valid, b_ready, b_we, b_rsp_valid;
    logic [NW-1:0] b_wmask;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rsp_rdata;
    logic          sram_csb0, sram_web0;
    logic [NW-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.NUM_WMASKS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_req   (clear_req),
        .init_done   (init_done),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_we        (a_we),
        .a_wmask     (a_wmask),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_rdata (a_rsp_rdata),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_we        (b_we),
        .b_wmask     (b_wmask),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_rdata (b_rsp_rdata),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    // macro stand-in: registered read port, byte-masked writes
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int k = 0; k < NW; k++)
                    if (sram_wmask0[k]) mem[sram_addr0][8*k +: 8] <= sram_din0[8*k +: 8];
            end else begin
                sram_dout0 <= mem[sram_addr0];
            end
        end
    end

    // reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    int            m_ptr;
    bit            m_pend_a, m_pend_b, m_hold_a, m_hold_b;
    logic [DW-1:0] m_data_a, m_data_b;
    int            nvec = 0;
    int            nerr = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_port(input string tag);
        chk({tag, "_csb0"},  sram_csb0, 1);
        chk({tag, "_web0"},  sram_web0, 1);
        chk({tag, "_addr0"}, sram_addr0, 0);
        chk({tag, "_wmask"}, sram_wmask0, 0);
        chk({tag, "_din0"},  sram_din0, 0);
        chk({tag, "_aready"}, a_ready, 0);
        chk({tag, "_bready"}, b_ready, 0);
        chk({tag, "_done"},  init_done, 0);
        chk({tag, "_arsp"},  a_rsp_valid, 0);
    endtask

    // caller has already driven the first cycle; checks n sweep writes
    task automatic sweep(input int n, input int pulse_at);
        for (int i = 0; i < n; i++) begin
            if (i != 0) begin
                @(posedge clk); #1;
                clear_req = (i == pulse_at);
            end
            @(negedge clk);
            chk("clr_addr",  sram_addr0, i);
            chk("clr_csb0",  sram_csb0, 0);
            chk("clr_web0",  sram_web0, 0);
            chk("clr_wmask", sram_wmask0, 4'hF);
            chk("clr_din0",  sram_din0, 0);
            chk("clr_ready", {a_ready, b_ready}, 0);
            chk("clr_done",  init_done, 0);
            chk("clr_rsp",   {a_rsp_valid, b_rsp_valid}, 0);
        end
        clear_req = 1'b0;
        m_pend_a = 0; m_pend_b = 0; m_hold_a = 0; m_hold_b = 0;
        if (n == DEPTH)
            for (int j = 0; j < DEPTH; j++) ref_mem[j] = '0;
    endtask

    // one RUN cycle with inputs already driven
    task automatic run_check();
        int            g;
        logic          we;
        logic [NW-1:0] wm;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        @(negedge clk);
        g = -1;
        if (!clear_req) begin
            if (a_valid && b_valid) g = m_ptr;
            else if (a_valid)       g = 0;
            else if (b_valid)       g = 1;
        end
        chk("run_done",   init_done, 1);
        chk("a_ready",    a_ready, (g == 0));
        chk("b_ready",    b_ready, (g == 1));
        chk("csb0",       sram_csb0, (g < 0));
        chk("a_rsp_valid", a_rsp_valid, m_pend_a);
        chk("a_rsp_rdata", a_rsp_rdata, m_pend_a ? m_data_a : 32'h0);
        chk("b_rsp_valid", b_rsp_valid, m_pend_b);
        chk("b_rsp_rdata", b_rsp_rdata, m_pend_b ? m_data_b : 32'h0);
        m_pend_a = 0; m_pend_b = 0;
        if (g >= 0) begin
            we = (g == 0) ? a_we    : b_we;
            wm = (g == 0) ? a_wmask : b_wmask;
            ad = (g == 0) ? a_addr  : b_addr;
            wd = (g == 0) ? a_wdata : b_wdata;
            chk("web0", sram_web0, !we);
            chk("addr0", sram_addr0, ad);
            if (we) begin
                chk("wmask0", sram_wmask0, wm);
                chk("din0", sram_din0, wd);
                for (int k = 0; k < NW; k++)
                    if (wm[k]) ref_mem[ad][8*k +: 8] = wd[8*k +: 8];
            end else if (g == 0) begin
                m_pend_a = 1; m_data_a = ref_mem[ad];
            end else begin
                m_pend_b = 1; m_data_b = ref_mem[ad];
            end
            m_ptr = 1 - g;
        end else begin
            chk("web0_idle", sram_web0, 1);
        end
        m_hold_a = a_valid && (g != 0);
        m_hold_b = b_valid && (g != 1);
    endtask

    initial begin
        rst_n = 0; clear_req = 0;
        a_valid = 1; a_we = 0; a_wmask = '0; a_addr = '0; a_wdata = '0;
        b_valid = 1; b_we = 0; b_wmask = '0; b_addr = '0; b_wdata = '0;
        m_ptr = 0; m_pend_a = 0; m_pend_b = 0; m_hold_a = 0; m_hold_b = 0;
        m_data_a = '0; m_data_b = '0;

        // held in reset: port idle, nothing ready
        repeat (3) begin
            @(negedge clk);
            chk_idle_port("rst");
        end

        // release: full sweep, then done in cycle 1025
        @(posedge clk); #1;
        rst_n = 1; a_valid = 0; b_valid = 0;
        sweep(DEPTH, -1);

        // masked write then read of 0x005
        @(posedge clk); #1;
        a_valid = 1; a_we = 1; a_addr = 10'h005; a_wdata = 32'hDEADBEEF; a_wmask = 4'b0011;
        run_check();
        @(posedge clk); #1;
        a_we = 0;
        run_check();
        @(posedge clk); #1;
        a_valid = 0;
        b_valid = 1; b_we = 1; b_addr = 10'h006; b_wdata = 32'h12345678; b_wmask = 4'hF;
        run_check();
        chk("req029_rsp_valid", a_rsp_valid, 1);
        chk("req029_rdata", a_rsp_rdata, 32'h0000BEEF);

        // both requesters reading every cycle: strict alternation starting at a
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            a_valid = 1; a_we = 0; a_addr = AW'($urandom_range(0, 7));
            b_valid = 1; b_we = 0; b_addr = AW'($urandom_range(0, 7));
            run_check();
            chk("rr_alt_a", a_ready, (i % 2 == 0));
            chk("rr_alt_b", b_ready, (i % 2 == 1));
        end

        // random traffic against the model, honoring hold-while-stalled
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (!m_hold_a) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_we    = 1'($urandom_range(0, 1));
                a_addr  = AW'($urandom_range(0, 7));
                a_wdata = $urandom;
                a_wmask = NW'($urandom_range(0, 15));
            end
            if (!m_hold_b) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_we    = 1'($urandom_range(0, 1));
                b_addr  = AW'($urandom_range(0, 7));
                b_wdata = $urandom;
                b_wmask = NW'($urandom_range(0, 15));
            end
            run_check();
        end

        // clear request while a is waiting; a restarted mid-sweep pulse is ignored
        @(posedge clk); #1;
        a_valid = 1; a_we = 0; a_addr = 10'h005; b_valid = 0; clear_req = 1;
        run_check();
        chk("req031_a_ready", a_ready, 0);
        chk("req031_csb0", sram_csb0, 1);
        @(posedge clk); #1;
        clear_req = 0;
        sweep(DEPTH, 300);
        @(posedge clk); #1;
        run_check();
        chk("req031_first_grant", a_ready, 1);
        @(posedge clk); #1;
        a_valid = 0;
        run_check();
        chk("req031_cleared_rdata", a_rsp_rdata, 32'h0);

        // reset pulse in the middle of a sweep restarts from address 0
        @(posedge clk); #1;
        clear_req = 1;
        run_check();
        @(posedge clk); #1;
        clear_req = 0;
        sweep(10'h200, -1);
        @(posedge clk); #1;
        rst_n = 0;
        @(negedge clk);
        chk_idle_port("rst_mid");
        @(posedge clk); #1;
        rst_n = 1;
        m_ptr = 0;
        sweep(DEPTH, -1);
        @(posedge clk); #1;
        a_valid = 1; a_we = 0; a_addr = 10'h006;
        b_valid = 1; b_we = 0; b_addr = 10'h005;
        run_check();
        chk("post_rst_ptr_a", a_ready, 1);
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;
        run_check();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_WMASKS, default 4, meaning byte write-mask width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, meaning word address width (depth 1024).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear_req  input  1  single-cycle pulse; re-zeroes the whole memory.
REQ-007 SHALL have port init_done  output  1  high when the memory is cleared and requests are serviced.
REQ-008 SHALL have, for each requester X in {a,b}: X_valid in 1; X_ready out 1; X_we in 1; X_wmask in NUM_WMASKS; X_addr in ADDR_WIDTH; X_wdata in DATA_WIDTH; X_rsp_valid out 1; X_rsp_rdata out DATA_WIDTH.
REQ-009 SHALL have macro port-0 outputs sram_csb0 1, sram_web0 1, sram_wmask0 NUM_WMASKS, sram_addr0 ADDR_WIDTH, sram_din0 DATA_WIDTH, and input sram_dout0 DATA_WIDTH.

Function
REQ-010 SHALL implement FSM states CLEAR and RUN; reset enters CLEAR with clear address 0.
REQ-011 In CLEAR, SHALL drive csb0=0, web0=0, wmask0=all ones, din0=0, addr0=clear counter, and increment the counter every cycle.
REQ-012 SHALL go CLEAR->RUN on the edge that writes address 2^ADDR_WIDTH-1; the counter wraps to 0. init_done SHALL be registered and go high in the first RUN cycle.
REQ-013 In RUN, clear_req=1 SHALL force CLEAR at the next edge with counter 0 and init_done=0. That cycle grants nothing; clear_req takes priority over both requesters.
REQ-014 clear_req in CLEAR SHALL be ignored (the sweep is not restarted).
REQ-015 X_ready SHALL be 0 in CLEAR. In RUN it SHALL be combinational: high only for the granted requester with X_valid=1.
REQ-016 A transfer occurs when X_valid && X_ready at a rising edge. Requesters SHALL hold their request fields stable while valid and not ready.
REQ-017 Arbitration SHALL be round-robin. With one valid requester, that requester is granted. With both valid, the priority pointer decides and then points to the other requester. Pointer reset value is a.
REQ-018 During a grant, SHALL drive csb0=0, web0=~X_we, wmask0=X_wmask, addr0=X_addr, din0=X_wdata. With no grant, csb0=1 and web0=1.
REQ-019 A read (X_we=0) accepted at edge N SHALL pulse X_rsp_valid for exactly the cycle after edge N, with X_rsp_rdata = sram_dout0 during that cycle. Latency is 1 cycle.
REQ-020 A write SHALL produce no response. Write-then-read to the same address in back-to-back grants SHALL return the new data.
REQ-021 Sustained throughput SHALL be one access per cycle. Responses have no backpressure.
REQ-022 X_rsp_rdata SHALL be 0 whenever X_rsp_valid=0.

Reset
REQ-023 Assertion of rst_n=0 SHALL immediately set: state=CLEAR, clear counter=0, init_done=0, rsp_valid a/b=0, pointer=a.
REQ-024 During reset, outputs SHALL be: sram_csb0=1, sram_web0=1, X_ready=0, and sram_addr0/wmask0/din0=0.
REQ-025 Reset asserted mid-CLEAR or mid-RUN SHALL abandon the in-flight response and restart the sweep from address 0 after deassertion.

Structure
REQ-026 A shared package sram_ctrl_pkg SHALL hold the state enum (CLEAR, RUN), the DEPTH constant and the default width constants.
REQ-027 Arbitration SHALL live in one sub-module rr_arb2 (2 requests in, 2 one-hot grants out, pointer update on accept).

Verification
REQ-028 Reset release -> exactly 1024 write cycles to addresses 0..1023 with din0=0 and wmask0=4'hF, then init_done=1 in cycle 1025.
REQ-029 a writes 0xDEADBEEF to 0x005 with wmask 4'b0011, then reads 0x005 -> a_rsp_valid pulses 1 cycle later with rdata 0x0000BEEF.
REQ-030 a and b valid every cycle for 6 cycles (reads) -> grants alternate a,b,a,b,a,b, and each requester gets exactly one rsp_valid per accept.
REQ-031 clear_req in RUN while a_valid=1 -> a_ready=0 in that cycle, init_done falls, 1024 clear writes follow, then a is granted in the first RUN cycle.
REQ-032 rst_n pulsed low at clear address 0x200 -> csb0=1 during reset, and after release the sweep restarts at address 0.
